serial_pattern_tx: RTL and testbench

- Serial bit-stream transmitter. It is the driving end for the team's small serial sequence-detector FSMs.
- Accepts a parallel word and a repeat count on a valid/ready command port.
- Each frame on a single registered output bit is: a run of '1' preamble bits, then the data word MSB-first, then one '0' gap bit.
- Used as the stimulus/source block feeding detector-style receivers on the same serial line.

---
 rtl/serial_pattern_pkg.sv | 13 +
 rtl/piso_shift.sv | 44 ++++
 rtl/serial_pattern_tx.sv | 137 +++++++++++++
 tb/tb_serial_pattern_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared types for the serial pattern transmitter: FSM state encoding and frame constants.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int GAP_LEN = 1;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, MSB first; load wins over shift.
// msb_next is the MSB the register will hold after the coming edge, so callers can register it.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb_next
);

  logic [WIDTH-1:0] sr;
  logic             shifted_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  generate
    if (WIDTH > 1) begin : g_wide
      assign shifted_msb = sr[WIDTH-2];
    end else begin : g_one
      assign shifted_msb = 1'b0;
    end
  endgenerate

  always_comb begin
    msb_next = sr[WIDTH-1];
    if (load) begin
      msb_next = din[WIDTH-1];
    end else if (shift) begin
      msb_next = shifted_msb;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame source: '1' preamble, data MSB-first, one '0' gap, repeated cmd_repeat+1 times.
// First preamble bit one cycle after the handshake; commands are accepted only when idle.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PREAMBLE_LEN = 2,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_repeat,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             tx_frame_start,
  output logic             done
);

  localparam int MAX_LEN   = (PREAMBLE_LEN > WIDTH) ? PREAMBLE_LEN : WIDTH;
  localparam int BIT_CNT_W = $clog2(MAX_LEN) + 1;

  localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] GAP_LAST  = BIT_CNT_W'(GAP_LEN - 1);

  state_t                 state;
  state_t                 state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]       rep_cnt;
  logic [WIDTH-1:0]       data_q;

  logic                   accept;
  logic                   sr_load;
  logic                   sr_shift;
  logic                   rep_dec;
  logic [WIDTH-1:0]       sr_din;
  logic                   msb_next;
  logic                   tx_bit_next;

  // The captured copy feeds every reload so cmd_data may change while busy.
  assign sr_din = accept ? cmd_data : data_q;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sr_load),
    .shift    (sr_shift),
    .din      (sr_din),
    .msb_next (msb_next)
  );

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    rep_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          sr_load    = 1'b1;
          state_next = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bit_cnt == PRE_LAST) begin
          state_next = DATA;
        end
      end
      DATA: begin
        sr_shift = 1'b1;
        if (bit_cnt == DATA_LAST) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (bit_cnt == GAP_LAST) begin
          if (rep_cnt != '0) begin
            rep_dec    = 1'b1;
            sr_load    = 1'b1;
            state_next = PREAMBLE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    tx_bit_next = (state_next == PREAMBLE) || ((state_next == DATA) && msb_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tx_bit         <= 1'b0;
      tx_active      <= 1'b0;
      tx_frame_start <= 1'b0;
      done           <= 1'b0;
      cmd_ready      <= 1'b1;
    end else begin
      state          <= state_next;
      tx_bit         <= tx_bit_next;
      tx_active      <= (state_next != IDLE);
      tx_frame_start <= (state_next == PREAMBLE) && (state != PREAMBLE);
      done           <= (state == GAP) && (state_next == IDLE);
      cmd_ready      <= (state_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rep_cnt <= '0;
      data_q  <= '0;
    end else begin
      if ((state_next != state) || (state == IDLE)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (accept) begin
        rep_cnt <= cmd_repeat;
        data_q  <= cmd_data;
      end else if (rep_dec) begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: driver pushes the expected per-cycle bit stream on each accepted command,
// a negedge monitor pops and compares every output.
module tb_serial_pattern_tx;

  localparam int W  = 8;
  localparam int PL = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_repeat = '0;
  logic          cmd_ready;
  logic          tx_bit;
  logic          tx_active;
  logic          tx_frame_start;
  logic          done;

  typedef struct packed {
    logic b;
    logic fs;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic exp_act;
  logic done_pending = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_pattern_tx #(
    .WIDTH        (W),
    .PREAMBLE_LEN (PL),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_repeat     (cmd_repeat),
    .tx_bit         (tx_bit),
    .tx_active      (tx_active),
    .tx_frame_start (tx_frame_start),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: one frame = PL ones, data MSB first, a single zero; repeated r+1 times.
  task automatic push_cmd(input logic [W-1:0] d, input logic [CW-1:0] r);
    int nfr;
    nfr = int'(r) + 1;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < PL; i++) exp_q.push_back('{1'b1, (i == 0), 1'b0});
      for (int i = 0; i < W; i++)  exp_q.push_back('{d[W-1-i], 1'b0, 1'b0});
      exp_q.push_back('{1'b0, 1'b0, (f == nfr - 1)});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_pending = 1'b0;
    end else begin
      exp_act = (exp_q.size() != 0);
      check("tx_active", tx_active, exp_act);
      check("cmd_ready", cmd_ready, !exp_act);
      check("done", done, done_pending);
      done_pending = 1'b0;
      if (exp_act) begin
        e = exp_q.pop_front();
        check("tx_bit", tx_bit, e.b);
        check("tx_frame_start", tx_frame_start, e.fs);
        done_pending = e.last;
      end else begin
        check("idle_tx_bit", tx_bit, 1'b0);
        check("idle_frame_start", tx_frame_start, 1'b0);
      end
    end
  end

  task automatic send_cmd(input logic [W-1:0] d, input logic [CW-1:0] r);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_repeat = r;
    while (!cmd_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1 within 400 cycles", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_cmd(d, r);
      #1;
      cmd_valid  = 1'b0;
      cmd_data   = W'($urandom);
      cmd_repeat = CW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d expected bits left, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_bit"}, tx_bit, 1'b0);
    check({tag, "_tx_active"}, tx_active, 1'b0);
    check({tag, "_frame_start"}, tx_frame_start, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #(1000000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  d;
    logic [CW-1:0] r;
    int            gap;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #3 rst_n = 1'b1;

    send_cmd(8'hA5, 4'd0);
    wait_idle();

    send_cmd(8'hFF, 4'd2);
    wait_idle();

    // Second command is held valid and must start right after the done cycle.
    send_cmd(8'hA5, 4'd0);
    send_cmd(8'h00, 4'd0);
    wait_idle();

    send_cmd(8'hA5, 4'd0);
    repeat (5) @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_data   = 8'h3C;
    cmd_repeat = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    send_cmd(8'hA5, 4'd0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_cmd(W'($urandom), 4'hF);
    wait_idle();

    for (int k = 0; k < 30; k++) begin
      d   = W'($urandom);
      r   = CW'($urandom_range(0, 3));
      gap = $urandom_range(0, 3);
      send_cmd(d, r);
      if (gap != 0) begin
        while (exp_q.size() != 0) @(negedge clk);
        repeat (gap) @(negedge clk);
      end
    end
    wait_idle();

    check("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
